// File: rtl/pipeline_hazard_unit.sv
// Hazard controller for a five-stage MIPS pipeline. Tracks the register-write
// state of the instructions in EX, MEM and WB, and from that drives the PC and
// pipe-register enables/flushes, the EX operand forwarding selects, and the
// squash of wrong-path instructions when a redirect resolves in MEM.
// Also keeps saturating stall/flush cycle counters for performance debug.
module pipeline_hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic [4:0]       id_dest,
  input  logic             mem_redirect,
  input  logic             ext_stall,
  output logic             pc_enable,
  output logic             ifid_enable,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10,
    ST_HOLD  = 2'b11
  } action_e;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic [4:0] dest;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
  } slot_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d, mem_d, wb_d;
  slot_t id_slot;
  action_e state_q, state_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic ex_prod, mem_prod, wb_prod;
  logic ex_load;
  logic rs_hazard, rt_hazard, stall_req;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  // Register 0 is hard-wired, so a slot writing it never produces a value.
  function automatic logic is_producer(input slot_t s);
    return s.valid && s.regwrite && (s.dest != 5'd0);
  endfunction

  assign id_slot = '{valid:    id_valid,
                     regwrite: id_regwrite,
                     memread:  id_memread,
                     dest:     id_dest,
                     rs:       id_rs,
                     rt:       id_rt,
                     uses_rs:  id_uses_rs,
                     uses_rt:  id_uses_rt};

  assign ex_prod  = is_producer(ex_q);
  assign mem_prod = is_producer(mem_q);
  assign wb_prod  = is_producer(wb_q);
  assign ex_load  = ex_prod && ex_q.memread;

  // Load-use against EX and same-cycle RF write/read against WB need a bubble;
  // MEM producers and non-load EX producers are covered by forwarding.
  always_comb begin
    rs_hazard = id_uses_rs && ((ex_load && (ex_q.dest == id_rs)) ||
                               (wb_prod && (wb_q.dest == id_rs)));
    rt_hazard = id_uses_rt && ((ex_load && (ex_q.dest == id_rt)) ||
                               (wb_prod && (wb_q.dest == id_rt)));
    stall_req = id_valid && (rs_hazard || rt_hazard);
  end

  // Choose this cycle's action by priority: HOLD > FLUSH > STALL > RUN.
  always_comb begin
    if (ext_stall)         state_d = ST_HOLD;
    else if (mem_redirect) state_d = ST_FLUSH;
    else if (stall_req)    state_d = ST_STALL;
    else                   state_d = ST_RUN;
  end

  // Advance the scoreboard and counters according to the chosen action.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which is what keeps synthesis from inferring a latch.
  always_comb begin
    ex_d          = ex_q;
    mem_d         = mem_q;
    wb_d          = wb_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    unique case (state_d)
      ST_HOLD: ;
      ST_FLUSH: begin
        wb_d        = mem_q;
        mem_d       = '0;
        ex_d        = '0;
        if (flush_count_q != '1) flush_count_d = flush_count_q + CNT_W'(1);
      end
      ST_STALL: begin
        wb_d        = mem_q;
        mem_d       = ex_q;
        ex_d        = '0;
        if (stall_count_q != '1) stall_count_d = stall_count_q + CNT_W'(1);
      end
      default: begin
        wb_d        = mem_q;
        mem_d       = ex_q;
        ex_d        = id_slot;
      end
    endcase
  end

  // Forwarding selects for the instruction sitting in EX; MEM beats WB.
  always_comb begin
    fwd_a_raw = FWD_RF;
    fwd_b_raw = FWD_RF;
    if (ex_q.valid) begin
      if (ex_q.uses_rs && mem_prod && (mem_q.dest == ex_q.rs))     fwd_a_raw = FWD_MEM;
      else if (ex_q.uses_rs && wb_prod && (wb_q.dest == ex_q.rs))  fwd_a_raw = FWD_WB;
      if (ex_q.uses_rt && mem_prod && (mem_q.dest == ex_q.rt))     fwd_b_raw = FWD_MEM;
      else if (ex_q.uses_rt && wb_prod && (wb_q.dest == ex_q.rt))  fwd_b_raw = FWD_WB;
    end
  end

  // Pipe-register controls; held at the free-running values while in reset.
  always_comb begin
    pc_enable   = 1'b1;
    ifid_enable = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;
    if (reset) begin
      fwd_a = fwd_a_raw;
      fwd_b = fwd_b_raw;
      unique case (state_d)
        ST_HOLD: begin
          pc_enable   = 1'b0;
          ifid_enable = 1'b0;
        end
        ST_FLUSH: begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end
        ST_STALL: begin
          pc_enable   = 1'b0;
          ifid_enable = 1'b0;
          idex_flush  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State registers: scoreboard slots, last action, performance counters.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      state_q       <= ST_RUN;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign state       = state_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

  // Slot fields carried along for debug visibility but not needed by any
  // decision once the instruction has left EX.
  logic unused_fields;
  assign unused_fields = ^{mem_q.memread, mem_q.rs, mem_q.rt, mem_q.uses_rs, mem_q.uses_rt,
                           wb_q.memread, wb_q.rs, wb_q.rt, wb_q.uses_rs, wb_q.uses_rt};

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed-vector bench for pipeline_hazard_unit. The driver applies one
// vector per cycle and queues the hand-computed response; a monitor pops and
// compares on the falling edge.
module tb_pipeline_hazard_unit;

  localparam int CNT_W = 16;

  // {pc_enable, ifid_enable, ifid_flush, idex_flush, exmem_flush}
  localparam logic [4:0] C_RUN   = 5'b11000;
  localparam logic [4:0] C_STALL = 5'b00010;
  localparam logic [4:0] C_FLUSH = 5'b11111;
  localparam logic [4:0] C_HOLD  = 5'b00000;

  typedef struct {
    string            name;
    logic [4:0]       ctrl;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic [1:0]       st;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread;
  logic [4:0] id_rs, id_rt, id_dest;
  logic mem_redirect, ext_stall;
  logic pc_enable, ifid_enable, ifid_flush, idex_flush, exmem_flush;
  logic [1:0] fwd_a, fwd_b, state;
  logic [CNT_W-1:0] stall_count, flush_count;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  pipeline_hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_dest(id_dest),
    .mem_redirect(mem_redirect), .ext_stall(ext_stall),
    .pc_enable(pc_enable), .ifid_enable(ifid_enable), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic rw,
                        input logic mr, input logic [4:0] dest);
    id_valid = v;  id_rs = rs;  id_rt = rt;
    id_uses_rs = urs;  id_uses_rt = urt;
    id_regwrite = rw;  id_memread = mr;  id_dest = dest;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  // Queue the response for the inputs just applied, then move to next cycle.
  task automatic push_exp(input string name, input logic [4:0] ctrl, input logic [1:0] fa,
                          input logic [1:0] fb, input logic [1:0] st,
                          input logic [CNT_W-1:0] sc, input logic [CNT_W-1:0] fc);
    exp_t e;
    e.name = name; e.ctrl = ctrl; e.fa = fa; e.fb = fb; e.st = st; e.sc = sc; e.fc = fc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input logic [CNT_W-1:0] sc, input logic [CNT_W-1:0] fc);
    idle();
    mem_redirect = 1'b0;
    ext_stall    = 1'b0;
    for (int i = 0; i < 3; i++) push_exp("drain", C_RUN, 2'b00, 2'b00, 2'b00, sc, fc);
  endtask

  // Monitor: compare every queued response on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".ctrl"}, {27'd0, pc_enable, ifid_enable, ifid_flush, idex_flush, exmem_flush}, {27'd0, e.ctrl});
        check({e.name, ".fwd_a"}, {30'd0, fwd_a}, {30'd0, e.fa});
        check({e.name, ".fwd_b"}, {30'd0, fwd_b}, {30'd0, e.fb});
        check({e.name, ".state"}, {30'd0, state}, {30'd0, e.st});
        check({e.name, ".stall_count"}, {16'd0, stall_count}, {16'd0, e.sc});
        check({e.name, ".flush_count"}, {16'd0, flush_count}, {16'd0, e.fc});
      end
    end
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    mem_redirect = 1'b0;
    ext_stall = 1'b0;
    idle();
    @(posedge clk);
    #1;
    push_exp("in_reset", C_RUN, 2'b00, 2'b00, 2'b00, 0, 0);
    reset = 1'b1;
    push_exp("post_reset", C_RUN, 2'b00, 2'b00, 2'b00, 0, 0);

    // lw $8,0($1) ; add $9,$8,$1 -> one bubble, then fwd_a=10
    set_id(1, 5'd1, 5'd0, 1, 0, 1, 1, 5'd8);
    push_exp("lu_lw", C_RUN, 2'b00, 2'b00, 2'b00, 0, 0);
    set_id(1, 5'd8, 5'd1, 1, 1, 1, 0, 5'd9);
    push_exp("lu_stall", C_STALL, 2'b00, 2'b00, 2'b00, 0, 0);
    push_exp("lu_release", C_RUN, 2'b00, 2'b00, 2'b01, 1, 0);
    idle();
    push_exp("lu_fwd", C_RUN, 2'b10, 2'b00, 2'b00, 1, 0);
    drain(1, 0);

    // add $8,$1,$2 ; sub $9,$8,$8 -> no stall, both operands from EX/MEM
    set_id(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd8);
    push_exp("ex_add", C_RUN, 2'b00, 2'b00, 2'b00, 1, 0);
    set_id(1, 5'd8, 5'd8, 1, 1, 1, 0, 5'd9);
    push_exp("ex_sub_id", C_RUN, 2'b00, 2'b00, 2'b00, 1, 0);
    idle();
    push_exp("ex_fwd", C_RUN, 2'b01, 2'b01, 2'b00, 1, 0);
    drain(1, 0);

    // add $8 ; or $10 ; and $11 ; consumer of $8 while add is in WB
    set_id(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd8);
    push_exp("wb_add", C_RUN, 2'b00, 2'b00, 2'b00, 1, 0);
    set_id(1, 5'd3, 5'd4, 1, 1, 1, 0, 5'd10);
    push_exp("wb_or", C_RUN, 2'b00, 2'b00, 2'b00, 1, 0);
    set_id(1, 5'd5, 5'd6, 1, 1, 1, 0, 5'd11);
    push_exp("wb_and", C_RUN, 2'b00, 2'b00, 2'b00, 1, 0);
    set_id(1, 5'd8, 5'd7, 1, 1, 1, 0, 5'd12);
    push_exp("wb_stall", C_STALL, 2'b00, 2'b00, 2'b00, 1, 0);
    push_exp("wb_release", C_RUN, 2'b00, 2'b00, 2'b01, 2, 0);
    idle();
    push_exp("wb_rf_read", C_RUN, 2'b00, 2'b00, 2'b00, 2, 0);
    drain(2, 0);

    // redirect with valid EX and MEM slots
    set_id(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd13);
    push_exp("rd_a", C_RUN, 2'b00, 2'b00, 2'b00, 2, 0);
    set_id(1, 5'd3, 5'd4, 1, 1, 1, 0, 5'd14);
    push_exp("rd_b", C_RUN, 2'b00, 2'b00, 2'b00, 2, 0);
    set_id(1, 5'd13, 5'd14, 1, 1, 1, 0, 5'd15);
    mem_redirect = 1'b1;
    push_exp("rd_flush", C_FLUSH, 2'b00, 2'b00, 2'b00, 2, 0);
    mem_redirect = 1'b0;
    set_id(1, 5'd14, 5'd0, 1, 0, 1, 0, 5'd16);
    push_exp("rd_ex_empty", C_RUN, 2'b00, 2'b00, 2'b10, 2, 1);
    idle();
    push_exp("rd_mem_empty", C_RUN, 2'b00, 2'b00, 2'b00, 2, 1);
    drain(2, 1);

    // ext_stall for three cycles over a pending redirect
    set_id(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd17);
    push_exp("hd_a", C_RUN, 2'b00, 2'b00, 2'b00, 2, 1);
    set_id(1, 5'd17, 5'd3, 1, 1, 1, 0, 5'd18);
    push_exp("hd_b", C_RUN, 2'b00, 2'b00, 2'b00, 2, 1);
    idle();
    mem_redirect = 1'b1;
    ext_stall    = 1'b1;
    push_exp("hold1", C_HOLD, 2'b01, 2'b00, 2'b00, 2, 1);
    push_exp("hold2", C_HOLD, 2'b01, 2'b00, 2'b11, 2, 1);
    push_exp("hold3", C_HOLD, 2'b01, 2'b00, 2'b11, 2, 1);
    ext_stall = 1'b0;
    push_exp("hold_flush", C_FLUSH, 2'b01, 2'b00, 2'b11, 2, 1);
    mem_redirect = 1'b0;
    push_exp("hold_after", C_RUN, 2'b00, 2'b00, 2'b10, 2, 2);
    drain(2, 2);

    // lw $0 ; add $9,$0,$0 -> register 0 never stalls or forwards
    set_id(1, 5'd1, 5'd0, 1, 0, 1, 1, 5'd0);
    push_exp("r0_lw", C_RUN, 2'b00, 2'b00, 2'b00, 2, 2);
    set_id(1, 5'd0, 5'd0, 1, 1, 1, 0, 5'd9);
    push_exp("r0_use", C_RUN, 2'b00, 2'b00, 2'b00, 2, 2);
    idle();
    push_exp("r0_fwd", C_RUN, 2'b00, 2'b00, 2'b00, 2, 2);
    drain(2, 2);

    // reset asserted during a load-use stall sequence
    set_id(1, 5'd1, 5'd0, 1, 0, 1, 1, 5'd8);
    push_exp("rs_lw", C_RUN, 2'b00, 2'b00, 2'b00, 2, 2);
    set_id(1, 5'd8, 5'd1, 1, 1, 1, 0, 5'd9);
    push_exp("rs_stall", C_STALL, 2'b00, 2'b00, 2'b00, 2, 2);
    reset = 1'b0;
    push_exp("rs_asserted", C_RUN, 2'b00, 2'b00, 2'b00, 0, 0);
    reset = 1'b1;
    idle();
    push_exp("rs_released", C_RUN, 2'b00, 2'b00, 2'b00, 0, 0);
    set_id(1, 5'd8, 5'd1, 1, 1, 1, 0, 5'd9);
    push_exp("rs_empty_sb", C_RUN, 2'b00, 2'b00, 2'b00, 0, 0);
    idle();
    push_exp("rs_final", C_RUN, 2'b00, 2'b00, 2'b00, 0, 0);

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
